// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of one UART byte serializer
// between NUM_REQ valid/ready byte sources.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int MAX_BURST    = 16,
   parameter int LOCK_TIMEOUT = 67488,
   parameter int GW           = $clog2(NUM_REQ),
   parameter int TW           = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 tx_start,
   output logic [7:0]           tx_data,
   input  logic                 tx_busy,
   output logic [GW-1:0]        grant_id,
   output logic                 grant_active
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SEND    = 3'd1,
      START   = 3'd2,
      WAIT_HI = 3'd3,
      WAIT_LO = 3'd4
   } state_t;

   state_t        state;
   logic [7:0]    burst_cnt;
   logic [TW-1:0] timeout_cnt;
   logic          last;
   logic [GW-1:0] next_id;
   logic [GW-1:0] cand;
   logic          any_valid;
   logic          holder_valid;
   logic          holder_last;
   logic [7:0]    holder_data;
   logic          handshake;

   // Rotating scan; walking k downwards leaves the nearest valid source after grant_id in next_id.
   always_comb begin
      next_id   = grant_id;
      any_valid = 1'b0;
      cand      = grant_id;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand      = GW'((int'(grant_id) + k) % NUM_REQ);
         next_id   = req_valid[cand] ? cand : next_id;
         any_valid = any_valid | req_valid[cand];
      end
   end

   // Select the lock holder's stream.
   always_comb begin
      holder_valid = 1'b0;
      holder_last  = 1'b0;
      holder_data  = 8'h00;
      for (int i = 0; i < NUM_REQ; i++) begin
         holder_valid = (GW'(i) == grant_id) ? req_valid[i]        : holder_valid;
         holder_last  = (GW'(i) == grant_id) ? req_last[i]         : holder_last;
         holder_data  = (GW'(i) == grant_id) ? req_data[8*i +: 8]  : holder_data;
      end
   end

   assign handshake = (state == SEND) && holder_valid && !tx_busy;

   // Only the lock holder is readied, and only while the serializer is free.
   always_comb begin
      req_ready = '0;
      if (handshake) begin
         req_ready[grant_id] = 1'b1;
      end else begin
         req_ready = '0;
      end
   end

   // Arbitration, lock bookkeeping and serializer handshake sequencing.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         tx_start     <= 1'b0;
         tx_data      <= 8'h00;
         grant_id     <= GW'(NUM_REQ - 1);
         grant_active <= 1'b0;
         burst_cnt    <= 8'd0;
         timeout_cnt  <= '0;
         last         <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         case (state)
            IDLE: begin
               if (any_valid) begin
                  grant_id     <= next_id;
                  grant_active <= 1'b1;
                  burst_cnt    <= 8'd0;
                  timeout_cnt  <= '0;
                  state        <= SEND;
               end
            end
            SEND: begin
               if (handshake) begin
                  tx_data     <= holder_data;
                  last        <= holder_last | (burst_cnt == 8'(MAX_BURST - 1));
                  burst_cnt   <= burst_cnt + 8'd1;
                  timeout_cnt <= '0;
                  tx_start    <= 1'b1;
                  state       <= START;
               end else if (!holder_valid) begin
                  // A silent holder keeps the lock only for LOCK_TIMEOUT clocks.
                  if (timeout_cnt == TW'(LOCK_TIMEOUT - 1)) begin
                     timeout_cnt  <= '0;
                     grant_active <= 1'b0;
                     state        <= IDLE;
                  end else begin
                     timeout_cnt <= timeout_cnt + TW'(1);
                  end
               end
            end
            START: begin
               state <= WAIT_HI;
            end
            WAIT_HI: begin
               if (tx_busy) begin
                  state <= WAIT_LO;
               end
            end
            WAIT_LO: begin
               if (!tx_busy) begin
                  if (last) begin
                     grant_active <= 1'b0;
                     state        <= IDLE;
                  end else begin
                     state <= SEND;
                  end
               end
            end
            default: begin
               grant_active <= 1'b0;
               state        <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: scripted and random source streams against a
// transaction-level round-robin model, with a behavioural serializer.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
   localparam int NUM_REQ      = 4;
   localparam int MAX_BURST    = 16;
   localparam int LOCK_TIMEOUT = 100;
   localparam int GW           = 2;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 tx_start;
   logic [7:0]           tx_data;
   logic                 tx_busy;
   logic [GW-1:0]        grant_id;
   logic                 grant_active;

   uart_tx_arbiter #(
      .NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST), .LOCK_TIMEOUT(LOCK_TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start),
      .tx_data(tx_data), .tx_busy(tx_busy), .grant_id(grant_id),
      .grant_active(grant_active)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [8:0] srcq [NUM_REQ][$];   // per source {last, data}
   logic [9:0] expq [$];            // expected transmissions {src, data}
   logic [7:0] obs [$];             // bytes seen at tx_start this round
   int model_grant;
   logic [7:0] ser_cap;
   int ser_dly, ser_len;
   int since_fall, first_fall, ready0_cycles, tx_count;
   logic ga_prev;
   logic [NUM_REQ-1:0] hs_mask;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic drive_sources();
      for (int i = 0; i < NUM_REQ; i++) begin
         if (srcq[i].size() > 0) begin
            req_valid[i]       = 1'b1;
            req_data[8*i +: 8] = srcq[i][0][7:0];
            req_last[i]        = srcq[i][0][8];
         end else begin
            req_valid[i]       = 1'b0;
            req_data[8*i +: 8] = 8'h00;
            req_last[i]        = 1'b0;
         end
      end
   endtask

   task automatic clear_bench();
      for (int i = 0; i < NUM_REQ; i++) srcq[i].delete();
      expq.delete();
      tx_busy     = 1'b0;
      ser_dly     = 0;
      ser_len     = 0;
      model_grant = NUM_REQ - 1;
      ga_prev     = 1'b0;
   endtask

   // Round-robin with packet lock: lock ends on last flag, burst cap, or an empty stream (timeout).
   task automatic build_expected();
      logic [8:0] cq [NUM_REQ][$];
      logic [8:0] b;
      int g, cnt;
      bit found, done, more;
      for (int i = 0; i < NUM_REQ; i++) cq[i] = srcq[i];
      g = model_grant;
      more = 1'b1;
      while (more) begin
         found = 1'b0;
         for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && cq[(g + k) % NUM_REQ].size() > 0) begin
               g = (g + k) % NUM_REQ;
               found = 1'b1;
            end
         end
         if (!found) begin
            more = 1'b0;
         end else begin
            cnt = 0;
            done = 1'b0;
            while (!done) begin
               b = cq[g].pop_front();
               expq.push_back({GW'(g), b[7:0]});
               cnt++;
               done = b[8] || (cnt == MAX_BURST) || (cq[g].size() == 0);
            end
         end
      end
      model_grant = g;
   endtask

   // One clock: mid-cycle checks at negedge, then source/serializer updates just after posedge.
   task automatic cycle();
      logic [9:0] e;
      @(negedge clk);
      check("ready_only_valid", req_ready & ~req_valid, 0);
      check("ready_onehot0", $onehot0(req_ready), 1);
      if (req_ready != '0) check("ready_holder", {tx_busy, grant_active, req_ready[grant_id]}, 3'b011);
      if (ser_dly > 0 || ser_len > 0) check("tx_data_stable", tx_data, ser_cap);
      if (req_ready[0]) ready0_cycles++;
      hs_mask = req_ready & req_valid;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) if (hs_mask[i]) void'(srcq[i].pop_front());
      since_fall++;
      if (ser_len > 0) begin
         ser_len--;
         if (ser_len == 0) begin
            tx_busy = 1'b0;
            since_fall = 0;
         end
      end else if (ser_dly > 0) begin
         ser_dly--;
         if (ser_dly == 0) begin
            tx_busy = 1'b1;
            ser_len = $urandom_range(3, 6);
         end
      end
      if (tx_start === 1'b1) begin
         tx_count++;
         check("start_ser_idle", {tx_busy, 1'b0 + (ser_dly > 0), 1'b0 + (ser_len > 0)}, 0);
         ser_cap = tx_data;
         ser_dly = $urandom_range(1, 2);
         obs.push_back(tx_data);
         if (expq.size() == 0) begin
            check("unexpected_tx", 1, 0);
         end else begin
            e = expq.pop_front();
            check("tx_src", grant_id, e[9:8]);
            check("tx_byte", tx_data, e[7:0]);
         end
      end
      if (ga_prev && !grant_active) begin
         check("fall_delay", (since_fall == 1) || (since_fall == LOCK_TIMEOUT + 1), 1);
         if (first_fall < 0) first_fall = since_fall;
      end
      ga_prev = grant_active;
      drive_sources();
   endtask

   function automatic bit src_pending();
      src_pending = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) if (srcq[i].size() > 0) src_pending = 1'b1;
   endfunction

   task automatic run_round(input string tag);
      int budget;
      build_expected();
      obs.delete();
      first_fall = -1;
      drive_sources();
      budget = 0;
      while ((src_pending() || expq.size() > 0 || tx_busy || ser_dly > 0 || ser_len > 0
              || grant_active) && budget < 4000) begin
         cycle();
         budget++;
      end
      check({tag, "_drain"}, budget < 4000, 1);
      check({tag, "_all_sent"}, expq.size(), 0);
      repeat (3) cycle();
      check({tag, "_grant_end"}, grant_id, model_grant);
   endtask

   task automatic check_obs(input string tag, input logic [7:0] want [$]);
      check({tag, "_count"}, obs.size(), want.size());
      for (int i = 0; i < want.size() && i < obs.size(); i++) check({tag, "_byte"}, obs[i], want[i]);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, req_ready, 0);
      check({tag, "_start"}, tx_start, 0);
      check({tag, "_data"}, tx_data, 0);
      check({tag, "_gid"}, grant_id, 3);
      check({tag, "_gact"}, grant_active, 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_bench();
      drive_sources();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] want [$];
      int n, budget, starts_before;
      logic lst;
      tx_count = 0;
      since_fall = 0;
      first_fall = -1;
      ready0_cycles = 0;
      req_valid = '0;
      req_last = '0;
      req_data = '0;
      do_reset();
      check_reset_outputs("por");

      // single byte from source 0
      srcq[0].push_back(9'h141);
      ready0_cycles = 0;
      run_round("t1");
      want = '{8'h41};
      check_obs("t1", want);
      check("t1_ready_cycles", ready0_cycles, 1);
      check("t1_gid", grant_id, 0);

      // all four one-byte packets, source 0 twice
      do_reset();
      srcq[0].push_back(9'h110); srcq[0].push_back(9'h114);
      srcq[1].push_back(9'h111);
      srcq[2].push_back(9'h112);
      srcq[3].push_back(9'h113);
      run_round("t2");
      want = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
      check_obs("t2", want);

      // packet lock: ABC from source 2 stays contiguous
      do_reset();
      srcq[1].push_back(9'h130); srcq[1].push_back(9'h131);
      srcq[2].push_back(9'h041); srcq[2].push_back(9'h042); srcq[2].push_back(9'h143);
      run_round("t3");
      want = '{8'h30, 8'h41, 8'h42, 8'h43, 8'h31};
      check_obs("t3", want);

      // burst cap at 16 bytes
      do_reset();
      for (int i = 0; i < 20; i++) srcq[0].push_back({1'b0, 8'(8'h60 + i)});
      srcq[3].push_back(9'h17F);
      run_round("t4");
      want.delete();
      for (int i = 0; i < 16; i++) want.push_back(8'(8'h60 + i));
      want.push_back(8'h7F);
      for (int i = 16; i < 20; i++) want.push_back(8'(8'h60 + i));
      check_obs("t4", want);

      // lock timeout after holder goes silent
      do_reset();
      srcq[1].push_back(9'h051);
      srcq[2].push_back(9'h152);
      run_round("t5");
      want = '{8'h51, 8'h52};
      check_obs("t5", want);
      check("t5_timeout_clks", first_fall, 101);

      // random streams, arbitration state carried across rounds
      for (int r = 0; r < 14; r++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            n = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 22);
            for (int j = 0; j < n; j++) begin
               lst = ($urandom_range(0, 3) == 0);
               if (j == n - 1 && $urandom_range(0, 3) != 0) lst = 1'b1;
               srcq[i].push_back({lst, 8'($urandom)});
            end
         end
         run_round("rnd");
      end

      // reset while waiting for the serializer to finish
      do_reset();
      srcq[0].push_back(9'h166);
      build_expected();
      drive_sources();
      budget = 0;
      while (tx_busy !== 1'b1 && budget < 200) begin
         cycle();
         budget++;
      end
      check("t6_busy_seen", budget < 200, 1);
      cycle();
      #2;
      reset = 1'b1;
      #1;
      check_reset_outputs("t6");
      clear_bench();
      drive_sources();
      repeat (2) cycle();
      reset = 1'b0;
      starts_before = tx_count;
      repeat (30) cycle();
      check("t6_no_start", tx_count - starts_before, 0);
      check_reset_outputs("t6_post");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
